zb_test_ctrl: RTL

- Parametrised test-access controller for the Zigbee TX/RX chain (inFIFO, MSK coder, decoder, CORDIC, CDR, outFIFO).
- Replaces fixed 8:1 select test muxing with:
  - a registered, handshaked configuration;
  - per-stage value injection;
  - a registered observe tap;
  - a triggered capture buffer that is read out over ready/valid.
- Sits between the top level's pad-side test inputs and the inter-stage signals.

---
 rtl/zb_test_pkg.sv | 30 +++
 rtl/zb_test_ctrl_if.sv | 27 ++
 rtl/zb_cap_ram.sv | 39 +++
 rtl/zb_test_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/zb_test_pkg.sv
// Shared types and default sizes for the Zigbee chain test-access controller.
package zb_test_pkg;

  localparam int DEF_NUM_TAPS = 8;
  localparam int DEF_TAP_W    = 4;
  localparam int DEF_DEPTH    = 16;

  typedef enum logic [1:0] {
    MODE_FUNC    = 2'd0,
    MODE_INJECT  = 2'd1,
    MODE_CAPTURE = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } state_e;

  // The reserved encoding falls back to plain functional muxing.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_INJECT;
      2'd2:    return MODE_CAPTURE;
      default: return MODE_FUNC;
    endcase
  endfunction

endpackage

// File: rtl/zb_test_ctrl_if.sv
// Configuration handshake and capture readout stream of the test controller.
interface zb_test_ctrl_if #(
  parameter int SEL_W = $clog2(zb_test_pkg::DEF_NUM_TAPS),
  parameter int TAP_W = zb_test_pkg::DEF_TAP_W
);

  logic             inCfgValid;
  logic [1:0]       inCfgMode;
  logic [SEL_W-1:0] inCfgSel;
  logic             outCfgReady;

  logic             outRdValid;
  logic [TAP_W-1:0] outRdData;
  logic             outRdLast;
  logic             inRdReady;

  modport master (
    output inCfgValid, inCfgMode, inCfgSel, inRdReady,
    input  outCfgReady, outRdValid, outRdData, outRdLast
  );

  modport slave (
    input  inCfgValid, inCfgMode, inCfgSel, inRdReady,
    output outCfgReady, outRdValid, outRdData, outRdLast
  );

endinterface

// File: rtl/zb_cap_ram.sv
// Capture buffer: one write port, one registered read port, array left unreset.
module zb_cap_ram #(
  parameter int DEPTH = zb_test_pkg::DEF_DEPTH,
  parameter int TAP_W = zb_test_pkg::DEF_TAP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [TAP_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [TAP_W-1:0]         rd_data
);

  logic [TAP_W-1:0] mem_q [DEPTH];
  logic [TAP_W-1:0] rd_data_d;
  logic [TAP_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/zb_test_ctrl.sv
// Test-access controller: registered config, per-stage injection, observe tap
// and a triggered capture buffer drained over ready/valid.
module zb_test_ctrl import zb_test_pkg::*; #(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int TAP_W    = DEF_TAP_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SEL_W    = $clog2(NUM_TAPS)
) (
  input  logic                      inClock,
  input  logic                      inReset,
  zb_test_ctrl_if.slave             bus,
  input  logic [NUM_TAPS*TAP_W-1:0] inFuncData,
  input  logic [NUM_TAPS*TAP_W-1:0] inTapData,
  input  logic [TAP_W-1:0]          inInjData,
  output logic [NUM_TAPS*TAP_W-1:0] outStageData,
  output logic [TAP_W-1:0]          outObsData,
  input  logic                      inTrigger,
  input  logic                      inSampleEn,
  input  logic                      inAbort,
  output logic                      outBusy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [SEL_W:0]   TAP_LIMIT = (SEL_W + 1)'(NUM_TAPS);
  localparam logic [SEL_W-1:0] TAP_MAX   = SEL_W'(NUM_TAPS - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic [TAP_W-1:0] obs_q, obs_d;
  logic             ram_we;
  logic [TAP_W-1:0] ram_rd_data;
  logic [TAP_W-1:0] tap_sel;
  logic [31:0]      sel_base;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return ({1'b0, s} >= TAP_LIMIT) ? TAP_MAX : s;
  endfunction

  assign sel_base = 32'(sel_q) * 32'(TAP_W);
  assign tap_sel  = inTapData[sel_base +: TAP_W];

  always_comb begin
    outStageData = inFuncData;
    if (mode_q == MODE_INJECT) begin
      outStageData[sel_base +: TAP_W] = inInjData;
    end
  end

  // Abort is applied last so it overrides trigger, sample and readout accept.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    obs_d      = tap_sel;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.inCfgValid) begin
          mode_d = decode_mode(bus.inCfgMode);
          sel_d  = clamp_sel(bus.inCfgSel);
          if (mode_d == MODE_CAPTURE) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (inTrigger) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (inSampleEn) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (wr_cnt_q == LAST_IDX) begin
            state_d = ST_READOUT;
          end
        end
      end
      ST_READOUT: begin
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
        end else if (bus.inRdReady) begin
          if (rd_last_q) begin
            state_d  = ST_IDLE;
            mode_d   = MODE_FUNC;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d   = rd_cnt_q + AW'(1);
            rd_valid_d = 1'b1;
          end
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (inAbort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      mode_d     = MODE_FUNC;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      rd_valid_d = 1'b0;
      ram_we     = 1'b0;
    end
    rd_last_d = rd_valid_d && (rd_cnt_d == LAST_IDX);
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FUNC;
      sel_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      obs_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      obs_q      <= obs_d;
    end
  end

  // Reading the next index keeps the held word stable while the consumer stalls.
  zb_cap_ram #(
    .DEPTH (DEPTH),
    .TAP_W (TAP_W)
  ) u_cap_ram (
    .clk     (inClock),
    .rst_n   (inReset),
    .we      (ram_we),
    .wr_addr (wr_cnt_q),
    .wr_data (tap_sel),
    .rd_addr (rd_cnt_d),
    .rd_data (ram_rd_data)
  );

  assign bus.outCfgReady = (state_q == ST_IDLE);
  assign bus.outRdValid  = rd_valid_q;
  assign bus.outRdLast   = rd_last_q;
  assign bus.outRdData   = rd_valid_q ? ram_rd_data : '0;
  assign outObsData      = obs_q;
  assign outBusy         = (state_q != ST_IDLE);

endmodule
